// File: rtl/rast_pkg.sv
// Shared rasterizer types and screen defaults, also imported by rast_triangle.
package rast_pkg;

  localparam int unsigned H_RES = 640;
  localparam int unsigned V_RES = 480;
  localparam int unsigned FRAC  = 8;
  localparam int unsigned Z_W   = 16;

  // Depth value written by a clear; farther than any real pixel.
  localparam logic [Z_W-1:0] Z_FAR = '1;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic [31:0] z;
    rgb_t        rgb;
  } pix_t;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StRead,
    StCmp,
    StWrite,
    StAck,
    StWaitLow,
    StClear
  } state_e;

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational clip test, linear buffer address and saturated depth for one pixel.
module fb_addr_calc #(
  parameter int unsigned H_RES  = rast_pkg::H_RES,
  parameter int unsigned V_RES  = rast_pkg::V_RES,
  parameter int unsigned FRAC   = rast_pkg::FRAC,
  parameter int unsigned Z_W    = rast_pkg::Z_W,
  parameter int unsigned ADDR_W = 19
) (
  input  logic [95:0]       xyz_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic [Z_W-1:0]    dz_o,
  output logic              clipped_o
);

  logic signed [31:0] px, py, pz;
  logic [ADDR_W-1:0]  row_base;

  assign px = $signed(xyz_i[95:64]) >>> FRAC;
  assign py = $signed(xyz_i[63:32]) >>> FRAC;
  assign pz = $signed(xyz_i[31:0]) >>> FRAC;

  assign clipped_o = px[31] || (px >= $signed(32'(H_RES))) ||
                     py[31] || (py >= $signed(32'(V_RES))) || pz[31];

  // Any bit above the depth word means the value is beyond range; clamp to far.
  assign dz_o = (|pz[31:Z_W]) ? '1 : pz[Z_W-1:0];

  // Row base py*H_RES built from the set bits of the constant width (shift-add).
  always_comb begin
    row_base = '0;
    for (int i = 0; i < 32; i++) begin
      if (H_RES[i]) row_base = row_base + (py[ADDR_W-1:0] << i);
    end
  end

  assign addr_o = row_base + px[ADDR_W-1:0];

endmodule

// File: rtl/zbuf_pixel_sink.sv
// Depth-tested pixel sink: clips, Z-tests and writes rasterizer pixels; clears the depth buffer.
module zbuf_pixel_sink #(
  parameter int unsigned H_RES  = rast_pkg::H_RES,
  parameter int unsigned V_RES  = rast_pkg::V_RES,
  parameter int unsigned FRAC   = rast_pkg::FRAC,
  parameter int unsigned Z_W    = rast_pkg::Z_W,
  parameter int unsigned ADDR_W = 19
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              pix_valid,
  input  logic [23:0]       pix_rgb,
  input  logic [95:0]       pix_xyz,
  output logic              pix_cont,
  input  logic              clear_start,
  output logic              clear_busy,
  output logic [ADDR_W-1:0] zb_addr,
  output logic              zb_we,
  output logic [Z_W-1:0]    zb_wdata,
  input  logic [Z_W-1:0]    zb_rdata,
  output logic [ADDR_W-1:0] fb_addr,
  output logic              fb_we,
  output logic [23:0]       fb_wdata,
  output logic [31:0]       pix_written
);

  import rast_pkg::*;

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(H_RES * V_RES - 1);

  state_e            state_q, state_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [Z_W-1:0]    dz_q, dz_d;
  rgb_t              rgb_q, rgb_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [31:0]       written_q, written_d;

  logic [ADDR_W-1:0] calc_addr;
  logic [Z_W-1:0]    calc_dz;
  logic              calc_clip;

  fb_addr_calc #(
    .H_RES  (H_RES),
    .V_RES  (V_RES),
    .FRAC   (FRAC),
    .Z_W    (Z_W),
    .ADDR_W (ADDR_W)
  ) u_addr_calc (
    .xyz_i     (pix_xyz),
    .addr_o    (calc_addr),
    .dz_o      (calc_dz),
    .clipped_o (calc_clip)
  );

  // Next-state logic: pixel handshake, depth test and clear sweep.
  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q | clear_start;
    addr_d    = addr_q;
    dz_d      = dz_q;
    rgb_d     = rgb_q;
    cnt_d     = cnt_q;
    written_d = written_q;
    unique case (state_q)
      StIdle: begin
        if (pend_q) begin
          state_d = StClear;
          cnt_d   = '0;
        end else if (pix_valid) begin
          state_d = StArm;
        end
      end
      // Producer colour is only valid on the second consecutive valid cycle.
      StArm: begin
        if (pix_valid) begin
          rgb_d   = pix_rgb;
          addr_d  = calc_addr;
          dz_d    = calc_dz;
          state_d = calc_clip ? StAck : StRead;
        end else begin
          state_d = StIdle;
        end
      end
      StRead:  state_d = StCmp;
      // Strictly nearer wins; on a tie the stored pixel stays.
      StCmp:   state_d = (dz_q < zb_rdata) ? StWrite : StAck;
      StWrite: begin
        written_d = written_q + 32'd1;
        state_d   = StAck;
      end
      StAck:   state_d = StWaitLow;
      // Hold off until the producer drops valid so a held pixel is not taken twice.
      StWaitLow: begin
        if (!pix_valid) state_d = StIdle;
      end
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastAddr) begin
          state_d   = StIdle;
          pend_d    = 1'b0;
          written_d = '0;
          cnt_d     = '0;
        end
      end
    endcase
  end

  // State and datapath registers, synchronous active-high reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q   <= StIdle;
      pend_q    <= 1'b0;
      addr_q    <= '0;
      dz_q      <= '0;
      rgb_q     <= '0;
      cnt_q     <= '0;
      written_q <= '0;
    end else begin
      state_q   <= state_d;
      pend_q    <= pend_d;
      addr_q    <= addr_d;
      dz_q      <= dz_d;
      rgb_q     <= rgb_d;
      cnt_q     <= cnt_d;
      written_q <= written_d;
    end
  end

  // Outputs decoded from registered state and latched pixel data only.
  always_comb begin
    pix_cont    = (state_q == StAck);
    zb_we       = (state_q == StWrite) || (state_q == StClear);
    fb_we       = (state_q == StWrite);
    zb_addr     = (state_q == StClear) ? cnt_q : addr_q;
    zb_wdata    = (state_q == StClear) ? '1 : dz_q;
    fb_addr     = addr_q;
    fb_wdata    = rgb_q;
    clear_busy  = pend_q;
    pix_written = written_q;
  end

endmodule

// File: tb/tb_zbuf_pixel_sink.sv
// Self-checking bench for zbuf_pixel_sink with a reduced screen height to keep clears short.
module tb_zbuf_pixel_sink;

  localparam int HR   = 640;
  localparam int VR   = 32;
  localparam int NPIX = HR * VR;

  logic        CLK = 1'b0;
  logic        RESET = 1'b1;
  logic        pix_valid = 1'b0;
  logic [23:0] pix_rgb = '0;
  logic [95:0] pix_xyz = '0;
  logic        clear_start = 1'b0;
  logic        pix_cont, clear_busy, zb_we, fb_we;
  logic [18:0] zb_addr, fb_addr;
  logic [15:0] zb_wdata, zb_rdata;
  logic [23:0] fb_wdata;
  logic [31:0] pix_written;
  logic        mem_init = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int nwr      = 0;

  logic [15:0] zmem  [NPIX];
  logic [15:0] ref_z [NPIX];

  zbuf_pixel_sink #(
    .H_RES  (HR),
    .V_RES  (VR),
    .FRAC   (8),
    .Z_W    (16),
    .ADDR_W (19)
  ) dut (
    .CLK         (CLK),
    .RESET       (RESET),
    .pix_valid   (pix_valid),
    .pix_rgb     (pix_rgb),
    .pix_xyz     (pix_xyz),
    .pix_cont    (pix_cont),
    .clear_start (clear_start),
    .clear_busy  (clear_busy),
    .zb_addr     (zb_addr),
    .zb_we       (zb_we),
    .zb_wdata    (zb_wdata),
    .zb_rdata    (zb_rdata),
    .fb_addr     (fb_addr),
    .fb_we       (fb_we),
    .fb_wdata    (fb_wdata),
    .pix_written (pix_written)
  );

  always #5 CLK = ~CLK;

  // External depth memory: one-cycle registered read.
  always @(posedge CLK) begin
    if (mem_init) begin
      for (int i = 0; i < NPIX; i++) zmem[i] <= 16'hFFFF;
    end else if (zb_we && int'(zb_addr) < NPIX) begin
      zmem[zb_addr] <= zb_wdata;
    end
    zb_rdata <= (int'(zb_addr) < NPIX) ? zmem[zb_addr] : 16'hFFFF;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                input logic [31:0] z, output bit clip, output int addr,
                                output logic [15:0] dz);
    int px, py, pz;
    px   = $signed(x) >>> 8;
    py   = $signed(y) >>> 8;
    pz   = $signed(z) >>> 8;
    clip = (px < 0) || (px >= HR) || (py < 0) || (py >= VR) || (pz < 0);
    dz   = (pz > 65535) ? 16'hFFFF : 16'(pz);
    addr = clip ? 0 : py * HR + px;
  endfunction

  task automatic send_pix(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                          input logic [23:0] rgb, input bit hold, input int clr_cyc);
    bit          clip, pass;
    int          addr, exp_ack, acks, ack_c, zw, fw, limit;
    logic [15:0] dz;
    logic [31:0] zaddr, zdata, faddr, fdata;
    model(x, y, z, clip, addr, dz);
    pass    = !clip && (dz < ref_z[addr]);
    exp_ack = clip ? 2 : (pass ? 5 : 4);
    acks = 0; ack_c = -1; zw = 0; fw = 0; limit = 30;
    zaddr = '0; zdata = '0; faddr = '0; fdata = '0;
    pix_xyz   = {x, y, z};
    pix_rgb   = rgb;
    pix_valid = 1'b1;
    for (int c = 1; c <= limit; c++) begin
      @(posedge CLK);
      #1;
      clear_start = (c == clr_cyc);
      if (clr_cyc > 0 && c == clr_cyc) chk("clear_busy_before", 32'(clear_busy), 32'd0);
      if (clr_cyc > 0 && c == clr_cyc + 2) chk("clear_busy_rise", 32'(clear_busy), 32'd1);
      if (pix_cont) begin
        acks++;
        if (ack_c < 0) begin
          ack_c = c;
          limit = c + (hold ? 13 : 2);
        end
      end
      if (zb_we) begin
        zw++;
        zaddr = 32'(zb_addr);
        zdata = 32'(zb_wdata);
      end
      if (fb_we) begin
        fw++;
        faddr = 32'(fb_addr);
        fdata = 32'(fb_wdata);
      end
      if (ack_c >= 0 && c == ack_c + (hold ? 10 : 0)) pix_valid = 1'b0;
    end
    pix_valid = 1'b0;
    chk("ack_cycle", 32'(ack_c), 32'(exp_ack));
    chk("ack_count", 32'(acks), 32'd1);
    chk("zb_write_count", 32'(zw), 32'(pass));
    chk("fb_write_count", 32'(fw), 32'(pass));
    if (pass) begin
      chk("zb_addr", zaddr, 32'(addr));
      chk("zb_wdata", zdata, 32'(dz));
      chk("fb_addr", faddr, 32'(addr));
      chk("fb_wdata", fdata, 32'(rgb));
      ref_z[addr] = dz;
      nwr++;
    end
    chk("pix_written", pix_written, 32'(nwr));
  endtask

  initial begin
    bit          clip;
    int          addr, k, bad, nonfar, px, py, pz, r;
    logic [15:0] dz;
    bit          done;

    for (int i = 0; i < NPIX; i++) ref_z[i] = 16'hFFFF;
    mem_init = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    RESET    = 1'b0;
    mem_init = 1'b0;
    chk("rst_pix_cont", 32'(pix_cont), 32'd0);
    chk("rst_zb_we", 32'(zb_we), 32'd0);
    chk("rst_fb_we", 32'(fb_we), 32'd0);
    chk("rst_zb_addr", 32'(zb_addr), 32'd0);
    chk("rst_fb_addr", 32'(fb_addr), 32'd0);
    chk("rst_zb_wdata", 32'(zb_wdata), 32'd0);
    chk("rst_fb_wdata", 32'(fb_wdata), 32'd0);
    chk("rst_clear_busy", 32'(clear_busy), 32'd0);
    chk("rst_pix_written", pix_written, 32'd0);

    // Directed: pass at 12810, then the same pixel ties and is rejected.
    send_pix(32'd10 << 8, 32'd20 << 8, 32'd5 << 8, 24'h010203, 1'b0, 0);
    send_pix(32'd10 << 8, 32'd20 << 8, 32'd5 << 8, 24'h010203, 1'b0, 0);
    // Clipped on x, y and z.
    send_pix(32'd640 << 8, 32'd20 << 8, 32'd5 << 8, 24'h0A0B0C, 1'b0, 0);
    send_pix(32'd10 << 8, -32'sd256, 32'd5 << 8, 24'h0A0B0C, 1'b0, 0);
    send_pix(32'd10 << 8, 32'd20 << 8, -32'sd768, 24'h0A0B0C, 1'b0, 0);
    // Valid held high long after the acknowledge.
    send_pix(32'd100 << 8, 32'd3 << 8, 32'd40 << 8, 24'h445566, 1'b1, 0);

    // Random pixels on a small patch so depth collisions happen.
    for (int i = 0; i < 24; i++) begin
      px = $urandom_range(0, 3);
      py = $urandom_range(0, 3);
      pz = $urandom_range(0, 40);
      r  = $urandom_range(0, 9);
      if (r == 0) px = HR + $urandom_range(0, 50);
      if (r == 1) py = -$urandom_range(1, 4);
      if (r == 2) pz = -$urandom_range(1, 4);
      if (r == 3) pz = 65535 + $urandom_range(0, 5000);
      if (r == 4) py = VR + $urandom_range(0, 3);
      send_pix(32'(px * 256 + $urandom_range(0, 255)), 32'(py * 256 + $urandom_range(0, 255)),
               32'(pz * 256 + $urandom_range(0, 255)), 24'($urandom), (i % 5) == 0, 0);
    end

    // Clear requested while the pixel is in the compare state.
    send_pix(32'd30 << 8, 32'd5 << 8, 32'd9 << 8, 24'h778899, 1'b0, 3);
    k = 0; bad = 0; done = 1'b0;
    for (int c = 0; c < NPIX + 100 && !done; c++) begin
      @(posedge CLK);
      #1;
      if (zb_we) begin
        if (zb_addr !== 19'(k) || zb_wdata !== 16'hFFFF) bad++;
        k++;
      end
      if (!clear_busy) done = 1'b1;
    end
    chk("clear_finished", 32'(done), 32'd1);
    chk("clear_write_count", 32'(k), 32'(NPIX));
    chk("clear_bad_writes", 32'(bad), 32'd0);
    chk("clear_pix_written", pix_written, 32'd0);
    chk("clear_zb_we_after", 32'(zb_we), 32'd0);
    nonfar = 0;
    for (int i = 0; i < NPIX; i++) if (zmem[i] !== 16'hFFFF) nonfar++;
    chk("clear_mem_far", 32'(nonfar), 32'd0);
    for (int i = 0; i < NPIX; i++) ref_z[i] = 16'hFFFF;
    nwr = 0;
    send_pix(32'd10 << 8, 32'd20 << 8, 32'd5 << 8, 24'h010203, 1'b0, 0);

    // Reset while the pixel is being written, with a clear pending.
    model(32'd11 << 8, 32'd20 << 8, 32'd7 << 8, clip, addr, dz);
    pix_xyz   = {32'd11 << 8, 32'd20 << 8, 32'd7 << 8};
    pix_rgb   = 24'hABCDEF;
    pix_valid = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      @(posedge CLK);
      #1;
      clear_start = (c == 2);
    end
    chk("wr_zb_we", 32'(zb_we), 32'd1);
    chk("wr_fb_we", 32'(fb_we), 32'd1);
    chk("wr_clear_busy", 32'(clear_busy), 32'd1);
    RESET     = 1'b1;
    pix_valid = 1'b0;
    @(posedge CLK);
    #1;
    chk("rstw_pix_cont", 32'(pix_cont), 32'd0);
    chk("rstw_zb_we", 32'(zb_we), 32'd0);
    chk("rstw_fb_we", 32'(fb_we), 32'd0);
    chk("rstw_pix_written", pix_written, 32'd0);
    chk("rstw_clear_busy", 32'(clear_busy), 32'd0);
    RESET = 1'b0;
    ref_z[addr] = dz;
    nwr = 0;
    // Same pixel again: it ties with the depth committed in the reset cycle.
    send_pix(32'd11 << 8, 32'd20 << 8, 32'd7 << 8, 24'hABCDEF, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
